// File: rtl/mmio_pkg.sv
// Shared definitions for the MIPS data-side bus controller: IO offsets, FSM states, region decode.
package mmio_pkg;

  localparam logic [31:0] LED_OFF = 32'h0000_0060;
  localparam logic [31:0] SW_OFF  = 32'h0000_0070;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  typedef enum logic [1:0] {REG_RAM, REG_LED, REG_SW, REG_BAD} region_e;

  // Word-granular decode; the byte offset inside a word never selects a different target
  function automatic region_e decode_region(input logic [31:0] addr, input logic [31:0] io_base);
    logic [31:0] word;
    word = {addr[31:2], 2'b00};
    if (addr < io_base)                return REG_RAM;
    else if (word == io_base + LED_OFF) return REG_LED;
    else if (word == io_base + SW_OFF)  return REG_SW;
    else                                return REG_BAD;
  endfunction

endpackage

// File: rtl/sw_sync_debounce.sv
// Two-flop synchroniser for the board switches; MMIO_DEBOUNCE_EN adds a per-bit stability filter.
module sw_sync_debounce #(
  parameter int unsigned N_SW    = 24,
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_in,
  output logic [N_SW-1:0] sw_out
);

  logic [N_SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  logic [N_SW-1:0][15:0] cnt_q;
  logic [N_SW-1:0]       out_q;

  // A bit flips only after DEB_CYC consecutive samples disagreeing with the current value
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (sync2_q[i] == out_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_CYC - 16'd1) begin
          out_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign sw_out = out_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYC;
  assign sw_out     = sync2_q;
`endif

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Data-side bus controller: RAM/LED/SW decode, load stall FSM, LED and read-data registers.
// Build with MMIO_DEBOUNCE_EN to debounce the switch register.
module mmio_bus_ctrl import mmio_pkg::*; #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RAM_AW  = 14,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned N_LED   = 24,
  parameter int unsigned N_SW    = 24,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [N_SW-1:0]   sw_in,
  output logic [N_LED-1:0]  led_out,
  output logic              bus_err
);

  localparam int unsigned CNT_W = 2;

  state_e            state_q, state_d;
  region_e           region;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RAM_AW-1:0] addr_q, addr_d, cpu_word;
  logic [DATA_W-1:0] rdata_q;
  logic [N_LED-1:0]  led_q;
  logic [N_SW-1:0]   sw_val;
  logic              rd_req, wr_req, cap, led_we, err_set;

  sw_sync_debounce #(.N_SW(N_SW), .DEB_CYC(DEB_CYC)) u_sw (
    .clock  (clock),
    .rst_n  (rst_n),
    .sw_in  (sw_in),
    .sw_out (sw_val)
  );

  // Requests are masked while reset is held so the core sees no stall or write strobe
  assign rd_req    = rst_n & cpu_rd & ~cpu_wr;
  assign wr_req    = rst_n & cpu_wr;
  assign region    = decode_region(cpu_addr, IO_BASE);
  assign cpu_word  = cpu_addr[RAM_AW+1:2];
  assign ram_addr  = (state_q == IDLE) ? cpu_word : addr_q;
  assign ram_wdata = cpu_wdata;
  assign led_out   = led_q;
  assign err_set   = (cpu_rd & cpu_wr) | ((cpu_rd | cpu_wr) & (region == REG_BAD));

  // Next-state and bus outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cap       = 1'b0;
    led_we    = 1'b0;
    ram_we    = 1'b0;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          ram_we = (region == REG_RAM);
          led_we = (region == REG_LED);
        end else if (rd_req) begin
          case (region)
            REG_RAM: begin
              cpu_stall = 1'b1;
              cnt_d     = CNT_W'(RAM_LAT - 1);
              addr_d    = cpu_word;
              state_d   = WAIT;
            end
            REG_LED: cpu_rdata = DATA_W'(led_q);
            REG_SW:  cpu_rdata = DATA_W'(sw_val);
            default: cpu_rdata = '0;
          endcase
        end
      end
      WAIT: begin
        cpu_stall = 1'b1;
        if (!cpu_rd) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap     = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        cpu_rdata = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      led_q   <= '0;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (cap)     rdata_q <= ram_rdata;
      if (led_we)  led_q   <= cpu_wdata[N_LED-1:0];
      if (err_set) bus_err <= 1'b1;
    end
  end

endmodule
